// File: rtl/aes_pkg.sv
// Shared definitions for the AES round-trip sequencer: mode encoding, round and key-word
// counts, FSM state encoding and the common datapath types.
package aes_pkg;

   localparam logic [1:0] MODE_128     = 2'd0;
   localparam logic [1:0] MODE_192     = 2'd1;
   localparam logic [1:0] MODE_256     = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL = 2'd3;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   localparam int NK_128 = 4;
   localparam int NK_192 = 6;
   localparam int NK_256 = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ENC  = 2'd1,
      ST_DEC  = 2'd2,
      ST_RESP = 2'd3
   } seq_state_e;

   typedef logic [3:0]   round_t;
   typedef logic [127:0] block_t;

endpackage

// File: rtl/aes_roundtrip_sequencer_if.sv
// Request, response and core-control bundle of the AES round-trip sequencer.
// slave = the sequencer itself; master = host front end plus the core datapath.
interface aes_roundtrip_sequencer_if;
   import aes_pkg::*;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_mode;
   block_t     req_state;

   logic [1:0] core_sel;
   logic       core_enc_en;
   logic       core_dec_en;
   logic       core_start;
   round_t     core_round;
   block_t     core_din;
   block_t     core_dout;

   logic       resp_valid;
   logic       resp_ready;
   block_t     resp_cipher;
   block_t     resp_plain;
   logic       resp_match;
   logic       resp_err;

   modport slave (
      input  req_valid, req_mode, req_state, core_dout, resp_ready,
      output req_ready, core_sel, core_enc_en, core_dec_en, core_start, core_round,
             core_din, resp_valid, resp_cipher, resp_plain, resp_match, resp_err
   );

   modport master (
      output req_valid, req_mode, req_state, core_dout, resp_ready,
      input  req_ready, core_sel, core_enc_en, core_dec_en, core_start, core_round,
             core_din, resp_valid, resp_cipher, resp_plain, resp_match, resp_err
   );

endinterface

// File: rtl/aes_round_counter.sv
// Round counter shared by the ENC and DEC passes: load latches the job's round count and
// restarts at 0, clr restarts at 0, inc steps; tc flags the final round (round == nr).
module aes_round_counter
   import aes_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   clr,
   input  logic   inc,
   input  round_t nr_in,
   output round_t round,
   output logic   tc
);

   round_t round_reg;
   round_t nr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_reg <= '0;
         nr_reg    <= '0;
      end else if (load) begin
         nr_reg    <= nr_in;
         round_reg <= '0;
      end else if (clr) begin
         round_reg <= '0;
      end else if (inc) begin
         round_reg <= round_reg + 4'd1;
      end
   end

   assign round = round_reg;
   assign tc    = (round_reg == nr_reg);

endmodule

// File: rtl/aes_roundtrip_sequencer.sv
// Owns the shared AES cores for one job: ENC rounds 0..nr, then DEC rounds 0..nr, then response.
// Define AES_SEQ_ROUNDTRIP_EN to include the decrypt pass; without it the job ends after ENC.
module aes_roundtrip_sequencer #(
   parameter int NR_128 = 10,
   parameter int NR_192 = 12,
   parameter int NR_256 = 14
) (
   input logic                      clk,
   input logic                      rst_n,
   aes_roundtrip_sequencer_if.slave bus
);
   import aes_pkg::*;

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] ENC  = ST_ENC;
`ifdef AES_SEQ_ROUNDTRIP_EN
   localparam logic [1:0] DEC  = ST_DEC;
`endif
   localparam logic [1:0] RESP = ST_RESP;

   logic [1:0] state_reg, state_next;
   logic [1:0] mode_reg;
   block_t     pt_reg, ct_reg, plain_reg;
   logic       match_reg, err_reg;
   round_t     nr_sel, round;
   logic       tc, enc_active, dec_active, accept, illegal;

   assign illegal    = (bus.req_mode == MODE_ILLEGAL);
   assign accept     = (state_reg == IDLE) && bus.req_valid;
   assign enc_active = (state_reg == ENC);
`ifdef AES_SEQ_ROUNDTRIP_EN
   assign dec_active = (state_reg == DEC);
`else
   assign dec_active = 1'b0;
`endif

   always_comb begin
      case (bus.req_mode)
         MODE_128: nr_sel = round_t'(NR_128);
         MODE_192: nr_sel = round_t'(NR_192);
         MODE_256: nr_sel = round_t'(NR_256);
         default:  nr_sel = '0;
      endcase
   end

   aes_round_counter u_round_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept && !illegal),
      .clr   ((enc_active || dec_active) && tc),
      .inc   ((enc_active || dec_active) && !tc),
      .nr_in (nr_sel),
      .round (round),
      .tc    (tc)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.req_valid) state_next = illegal ? RESP : ENC;
`ifdef AES_SEQ_ROUNDTRIP_EN
         ENC:  if (tc) state_next = DEC;
         DEC:  if (tc) state_next = RESP;
`else
         ENC:  if (tc) state_next = RESP;
`endif
         RESP: if (bus.resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Response registers are cleared on accept so an illegal job reports zeros, not stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         mode_reg  <= '0;
         pt_reg    <= '0;
         ct_reg    <= '0;
         plain_reg <= '0;
         match_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            mode_reg  <= bus.req_mode;
            pt_reg    <= bus.req_state;
            ct_reg    <= '0;
            plain_reg <= '0;
            match_reg <= 1'b0;
            err_reg   <= illegal;
         end
         if (enc_active && tc) ct_reg <= bus.core_dout;
`ifdef AES_SEQ_ROUNDTRIP_EN
         if (dec_active && tc) begin
            plain_reg <= bus.core_dout;
            match_reg <= (bus.core_dout == pt_reg);
         end
`endif
      end
   end

   assign bus.req_ready   = (state_reg == IDLE);
   assign bus.core_sel    = mode_reg;
   assign bus.core_enc_en = enc_active;
   assign bus.core_dec_en = dec_active;
   assign bus.core_round  = (enc_active || dec_active) ? round : '0;
   assign bus.core_start  = (enc_active || dec_active) && (round == '0);
   assign bus.core_din    = enc_active ? pt_reg : (dec_active ? ct_reg : '0);
   assign bus.resp_valid  = (state_reg == RESP);
   assign bus.resp_cipher = ct_reg;
   assign bus.resp_plain  = plain_reg;
   assign bus.resp_match  = match_reg;
   assign bus.resp_err    = err_reg;

endmodule

// File: tb/tb_aes_roundtrip_sequencer.sv
// Bench for aes_roundtrip_sequencer: behavioural core model, per-cycle timeline model of the
// job flow, FIPS-197 literal pins, backpressure, reset, mismatch and random jobs.
module tb_aes_roundtrip_sequencer;
   import aes_pkg::*;

`ifdef AES_SEQ_ROUNDTRIP_EN
   localparam bit RT = 1'b1;
   int lat_tab [3] = '{22, 26, 30};
`else
   localparam bit RT = 1'b0;
   int lat_tab [3] = '{11, 13, 15};
`endif
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   logic [127:0] ct_tab [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                128'h8ea2b7ca516745bfeafc49904b496089};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   corrupt = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   edges = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   aes_roundtrip_sequencer_if bus ();

   aes_roundtrip_sequencer #(.NR_128(10), .NR_192(12), .NR_256(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural core model ----------------
   function automatic int nr_of(input logic [1:0] m);
      case (m)
         2'd0: return 10;
         2'd1: return 12;
         2'd2: return 14;
         default: return 0;
      endcase
   endfunction

   function automatic logic [127:0] fips_ct(input logic [1:0] m);
      case (m)
         2'd0: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
         2'd1: return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
         default: return 128'h8ea2b7ca516745bfeafc49904b496089;
      endcase
   endfunction

   function automatic logic [127:0] key_of(input logic [1:0] m);
      return 128'h000102030405060708090a0b0c0d0e0f ^ {126'd0, m};
   endfunction

   // Real FIPS-197 answers for the standard vector, an invertible toy cipher otherwise.
   function automatic logic [127:0] enc_fn(input logic [127:0] x, input logic [1:0] m);
      int s;
      s = 8 * (int'(m) + 1);
      if (x == FIPS_PT) return fips_ct(m);
      return ((x << s) | (x >> (128 - s))) ^ key_of(m);
   endfunction

   function automatic logic [127:0] dec_fn(input logic [127:0] y, input logic [1:0] m);
      logic [127:0] z;
      int s;
      s = 8 * (int'(m) + 1);
      if (y == fips_ct(m)) return FIPS_PT;
      z = y ^ key_of(m);
      return (z >> s) | (z << (128 - s));
   endfunction

   // Output is only meaningful on the final round; junk elsewhere exposes wrong-round captures.
   always_comb begin
      bus.core_dout = ~bus.core_din ^ {32{bus.core_round}};
      if (bus.core_enc_en && int'(bus.core_round) == nr_of(bus.core_sel))
         bus.core_dout = enc_fn(bus.core_din, bus.core_sel);
      else if (bus.core_dec_en && int'(bus.core_round) == nr_of(bus.core_sel))
         bus.core_dout = dec_fn(bus.core_din, bus.core_sel) ^ {127'd0, corrupt};
   end

   // ---------------- timeline model + per-cycle compare ----------------
   bit           m_busy, m_resp, m_fresh = 1'b1;
   int           m_n, m_nr, m_total;
   logic [1:0]   m_mode;
   logic [127:0] m_pt, m_ct, m_pl;
   logic         m_match, m_err;

   always @(negedge clk) begin
      bit         enc, dec;
      logic [3:0] rnd;
      logic [127:0] din;
      if (!rst_n) begin
         m_busy = 0; m_resp = 0; m_fresh = 1; m_mode = 2'd0;
         m_ct = '0; m_pl = '0; m_match = 0; m_err = 0;
      end
      enc = m_busy && (m_n <= m_nr);
      dec = m_busy && (m_n > m_nr);
      rnd = enc ? 4'(m_n) : (dec ? 4'(m_n - m_nr - 1) : 4'd0);
      din = enc ? m_pt : (dec ? m_ct : '0);
      chk("ctrl{rdy,enc,dec,start,vld,sel,round}",
          {bus.req_ready, bus.core_enc_en, bus.core_dec_en, bus.core_start, bus.resp_valid,
           bus.core_sel, bus.core_round},
          {!m_busy && !m_resp, enc, dec, (enc || dec) && rnd == 4'd0, m_resp, m_mode, rnd});
      chk("core_din", bus.core_din, din);
      if (m_resp || m_fresh) begin
         chk("resp_cipher", bus.resp_cipher, m_ct);
         chk("resp_plain", bus.resp_plain, m_pl);
         chk("resp{match,err}", {bus.resp_match, bus.resp_err}, {m_match, m_err});
      end
      if (rst_n) begin
         if (m_resp) begin
            if (bus.resp_ready) m_resp = 0;
         end else if (m_busy) begin
            m_n++;
            if (m_n == m_total) begin m_busy = 0; m_resp = 1; end
         end else if (bus.req_valid) begin
            m_mode = bus.req_mode; m_pt = bus.req_state; m_fresh = 0; m_n = 0;
            if (bus.req_mode == 2'd3) begin
               m_err = 1; m_ct = '0; m_pl = '0; m_match = 0; m_resp = 1;
            end else begin
               m_err = 0; m_nr = nr_of(bus.req_mode);
               m_ct = enc_fn(m_pt, m_mode);
               m_pl = RT ? (dec_fn(m_ct, m_mode) ^ {127'd0, corrupt}) : '0;
               m_match = RT ? (m_pl == m_pt) : 1'b0;
               m_total = RT ? 2 * (m_nr + 1) : m_nr + 1;
               m_busy = 1;
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called #1 after a rising edge; returns #1 after the accept edge, with junk on req_* meanwhile.
   task automatic accept_req(input logic [1:0] m, input logic [127:0] pt, output int acc_edge);
      int guard = 0;
      bus.req_valid = 1'b1; bus.req_mode = m; bus.req_state = pt;
      @(negedge clk);
      while (!bus.req_ready && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) chk("accept_timeout", {127'd0, bus.req_ready}, 128'd1);
      @(posedge clk); #1;
      acc_edge = edges;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_mode  = 2'($urandom);
      bus.req_state = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Edges after the accept edge until resp_valid is seen (0 = first cycle after accept).
   task automatic wait_resp(output int lat);
      lat = 0;
      @(negedge clk);
      while (!bus.resp_valid && lat < 100) begin @(negedge clk); lat++; end
   endtask

   task automatic release_resp(input int hold);
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      bus.resp_ready = 1'b1; bus.req_valid = 1'b0;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   function automatic int lat_model(input logic [1:0] m);
      if (m == 2'd3) return 0;
      return RT ? 2 * (nr_of(m) + 1) : nr_of(m) + 1;
   endfunction

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, acc, hs;
      logic [1:0] m;
      logic [127:0] pt, snap_c, snap_p;
      bus.req_valid = 1'b0; bus.req_mode = 2'd0; bus.req_state = '0; bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // FIPS-197 vectors for all three key sizes
      for (int i = 0; i < 3; i++) begin
         accept_req(2'(i), FIPS_PT, acc);
         wait_resp(lat);
         $display("job fips mode=%0d lat=%0d ct=%h match=%0b", i, lat, bus.resp_cipher, bus.resp_match);
         chk("fips_latency", lat, lat_tab[i]);
         chk("fips_cipher", bus.resp_cipher, ct_tab[i]);
         chk("fips_plain", bus.resp_plain, RT ? FIPS_PT : 128'd0);
         chk("fips_match", {127'd0, bus.resp_match}, {127'd0, RT});
         release_resp(0);
      end

      // Illegal mode: immediate response, error flag, zero fields
      accept_req(2'd3, FIPS_PT, acc);
      wait_resp(lat);
      $display("job illegal lat=%0d err=%0b", lat, bus.resp_err);
      chk("illegal_latency", lat, 0);
      chk("illegal_err", {127'd0, bus.resp_err}, 128'd1);
      chk("illegal_cipher", bus.resp_cipher, 128'd0);
      release_resp(1);

      // Mismatch: decrypt model flips bit 0
      corrupt = 1'b1;
      accept_req(2'd0, FIPS_PT, acc);
      wait_resp(lat);
      $display("job mismatch lat=%0d match=%0b", lat, bus.resp_match);
      chk("mismatch_match", {127'd0, bus.resp_match}, 128'd0);
      chk("mismatch_plain", bus.resp_plain, RT ? (FIPS_PT ^ 128'd1) : 128'd0);
      release_resp(0);
      corrupt = 1'b0;

      // Backpressure with a second request pending
      accept_req(2'd1, 128'hfeedface0123456789abcdef55aa33cc, acc);
      wait_resp(lat);
      snap_c = bus.resp_cipher; snap_p = bus.resp_plain;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_mode = 2'd0; bus.req_state = FIPS_PT;
      repeat (10) begin
         @(negedge clk);
         chk("bp_req_ready", {127'd0, bus.req_ready}, 128'd0);
      end
      chk("bp_cipher_stable", bus.resp_cipher, snap_c);
      chk("bp_plain_stable", bus.resp_plain, snap_p);
      @(posedge clk); #1 bus.resp_ready = 1'b1;
      @(posedge clk); #1 bus.resp_ready = 1'b0;
      hs = edges;
      accept_req(2'd0, FIPS_PT, acc);
      chk("bp_accept_gap", acc - hs, 1);
      wait_resp(lat);
      $display("job backpressure-second lat=%0d gap=%0d", lat, acc - hs);
      chk("bp_second_latency", lat, lat_tab[0]);
      release_resp(0);

      // Reset during ENC round 5
      accept_req(2'd0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, acc);
      repeat (5) @(posedge clk);
      #1 chk("pre_reset_round", bus.core_round, 128'd5);
      rst_n = 1'b0; bus.req_valid = 1'b0;
      #1;
      chk("rst_ctrl{rdy,enc,dec,start,vld,sel,round}",
          {bus.req_ready, bus.core_enc_en, bus.core_dec_en, bus.core_start, bus.resp_valid,
           bus.core_sel, bus.core_round}, {1'b1, 10'd0});
      chk("rst_core_din", bus.core_din, 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      accept_req(2'd0, FIPS_PT, acc);
      wait_resp(lat);
      $display("job after-reset lat=%0d ct=%h", lat, bus.resp_cipher);
      chk("after_reset_latency", lat, lat_tab[0]);
      chk("after_reset_cipher", bus.resp_cipher, ct_tab[0]);
      release_resp(0);

      // Random jobs
      for (int j = 0; j < 24; j++) begin
         m  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         pt = {$urandom, $urandom, $urandom, $urandom};
         corrupt = ($urandom_range(0, 4) == 0);
         accept_req(m, pt, acc);
         wait_resp(lat);
         $display("job rand mode=%0d lat=%0d match=%0b err=%0b", m, lat, bus.resp_match, bus.resp_err);
         chk("rand_latency", lat, lat_model(m));
         release_resp($urandom_range(0, 3));
      end
      corrupt = 1'b0;

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
